// File: rtl/bin2bcd_seq_pkg.sv
// rtl/bin2bcd_seq_pkg.sv - shared types and sizing helpers for the sequential binary-to-BCD converter
package bin2bcd_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Smallest digit count whose decimal range strictly exceeds 2^width.
  function automatic int min_digits(input int width);
    longint lim;
    longint p;
    int     d;
    lim = longint'(1) << width;
    p   = 1;
    d   = 0;
    while (p <= lim) begin
      p = p * 10;
      d = d + 1;
    end
    return d;
  endfunction

  function automatic int cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/bin2bcd_seq_bcd_digit_adj.sv
// rtl/bin2bcd_seq_bcd_digit_adj.sv - double-dabble digit correction: add 3 when the digit is 5 or more
module bcd_digit_adj (
  input  logic [3:0] d_i,
  output logic [3:0] d_o
);

  assign d_o = (d_i >= 4'd5) ? (d_i + 4'd3) : d_i;

endmodule

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - iterative double-dabble converter, one bit per clock, level start/done handshake
module bin2bcd_seq
  import bin2bcd_seq_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5,
  parameter int SIGNED = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  neg,
  output logic                  busy,
  output logic                  done
);

  localparam int CW = cnt_width(WIDTH);

  if (DIGITS < min_digits(WIDTH)) begin : g_digits_check
    $error("bin2bcd_seq: DIGITS too small for WIDTH");
  end

  state_e                state_q;
  logic [WIDTH-1:0]      mag_q;
  logic [WIDTH-1:0]      mag_d;
  logic [4*DIGITS-1:0]   scratch_q;
  logic [4*DIGITS-1:0]   scratch_d;
  logic [4*DIGITS-1:0]   scratch_adj;
  logic [CW-1:0]         cnt_q;
  logic                  neg_pend_q;
  logic [4*DIGITS-1:0]   bcd_q;
  logic                  neg_q;
  logic                  cap_neg;
  logic [WIDTH-1:0]      cap_mag;

  // The most negative value negates to itself, which is already the correct unsigned magnitude.
  assign cap_neg = (SIGNED != 0) && bin[WIDTH-1];
  assign cap_mag = cap_neg ? (~bin + {{(WIDTH-1){1'b0}}, 1'b1}) : bin;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .d_i (scratch_q[4*g +: 4]),
      .d_o (scratch_adj[4*g +: 4])
    );
  end

  assign {scratch_d, mag_d} = {scratch_adj, mag_q} << 1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      mag_q      <= '0;
      scratch_q  <= '0;
      cnt_q      <= '0;
      neg_pend_q <= 1'b0;
      bcd_q      <= '0;
      neg_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            mag_q      <= cap_mag;
            neg_pend_q <= cap_neg;
            scratch_q  <= '0;
            cnt_q      <= '0;
            state_q    <= ST_CONV;
          end
        end
        ST_CONV: begin
          scratch_q <= scratch_d;
          mag_q     <= mag_d;
          cnt_q     <= cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH-1)) begin
            bcd_q   <= scratch_d;
            neg_q   <= neg_pend_q;
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (!start) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bcd  = bcd_q;
  assign neg  = neg_q;
  assign busy = (state_q == ST_CONV);
  assign done = (state_q == ST_DONE);

endmodule

// File: doc/bin2bcd_seq.md
Name: bin2bcd_seq

Overview:
- Sequential binary-to-BCD converter (iterative double-dabble) downstream of the shift-add multiplier.
- Its start input is driven by the multiplier's level-held done. When start is seen, it captures the product, converts it one bit per clock, and presents packed BCD digits plus a sign flag to the seven-segment display driver.
- Uses the same level handshake as the multiplier: done is held while start stays high.

Parameters:
- WIDTH, 16, width of binary input (product width).
- DIGITS, 5, number of BCD output digits; must satisfy 10^DIGITS > 2^WIDTH.
- SIGNED, 1, 1 = bin is two's complement (convert magnitude, report sign); 0 = unsigned.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  level request; normally the multiplier's done.
- bin  in  WIDTH  binary value; sampled only on the capture edge.
- bcd  out  4*DIGITS  packed BCD result; digit 0 (units) in bits [3:0].
- neg  out  1  result negative (always 0 when SIGNED=0).
- busy  out  1  conversion in progress.
- done  out  1  result valid.

Behaviour:
- Reset (async, any state incl. mid-conversion): state=IDLE, bcd=0, neg=0, busy=0, done=0, shift/scratch registers and counter cleared.
- States: IDLE, CONV, DONE (2-bit encoding; unused encoding -> IDLE).
- IDLE:
  - If start=1 at a rising edge, capture the operand: mag = (SIGNED && bin[WIDTH-1]) ? -bin : bin (WIDTH-bit unsigned result).
  - Latch neg_next = SIGNED && bin[WIDTH-1]; scratch BCD = 0; count = 0; go to CONV.
  - Otherwise stay in IDLE.
- CONV, each edge:
  - Every scratch digit >= 5 gets +3.
  - Then shift {scratch, mag} left by 1, so the mag MSB enters digit 0 bit 0.
  - count++.
  - On the edge completing shift WIDTH (count == WIDTH-1 before the edge), register the result into bcd, drive neg from neg_next, and go to DONE.
  - start is ignored while in CONV; deassertion does not abort.
- DONE:
  - done=1; stay while start=1.
  - On start=0, return to IDLE with done=0 on the next edge.
  - No restart is possible without a start low phase.
- Outputs: busy = (state==CONV); done = (state==DONE); both decoded from the registered state.
- bcd/neg update only on the completion edge and hold through IDLE and the next CONV until that conversion completes. The display never sees partial values.
- Latency: capture edge E0; WIDTH shift edges E1..EWIDTH; done=1 after EWIDTH, i.e. WIDTH+1 edges after start is sampled (17 for WIDTH=16).
- Most-negative input with SIGNED=1: magnitude 2^(WIDTH-1) is representable unsigned. Example: -32768 -> neg=1, bcd=32768.
- Zero input with SIGNED=1: neg=0.
- Start asserted in the same cycle rst deasserts: sampled normally at the first edge after reset release.

Decomposition:
- Shared package:
  - state localparams IDLE/CONV/DONE;
  - constant function computing minimal DIGITS from WIDTH;
  - counter width clog2(WIDTH).
- One natural sub-module: bcd_digit_adj, combinational 4-bit "if >=5 add 3" correction, instantiated DIGITS times via generate.

Test Plan:
- SIGNED=0, bin=0, start pulse held -> after 17 edges done=1, bcd=0x00000, neg=0, busy=0.
- SIGNED=0, bin=16'hFFFF -> bcd=0x65535, done asserted exactly 17 cycles after start sampled; busy high for cycles 1..16.
- SIGNED=1, bin=16'h8000 -> neg=1, bcd=0x32768. Then bin=16'hFB2E (-1234) -> neg=1, bcd=0x01234, and previous bcd held during the second conversion.
- start held high after done -> state stays DONE, done=1 for 10 extra cycles, no new capture. start low -> done=0 next edge, state IDLE.
- Mid-conversion rst at cycle 8 of CONV -> bcd=0, neg=0, busy=0, done=0 immediately (async). A following conversion of bin=255 -> bcd=0x00255.
- start dropped to 0 during CONV for 3 cycles -> conversion completes unaffected. Then done=1 for one cycle and return to IDLE since start=0.
